// File: rtl/smachine_pkg.sv
// Shared S-Machine constants: data memory geometry, arbiter state encoding and memory write polarity.
package smachine_pkg;
  localparam int   SM_ADDR_W = 8;
  localparam int   SM_DATA_W = 16;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DBG_ACC = 2'd2
  } arb_state_t;
endpackage

// File: rtl/dmem_arb_sel.sv
// Combinational next-owner select: CPU wins a conflict unless it has used up its burst allowance.
module dmem_arb_sel
  import smachine_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic             cpu_req,
  input  logic             dbg_req,
  input  logic [CNT_W-1:0] burst_cnt,
  output arb_state_t       next_state
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  always_comb begin
    next_state = IDLE;
    if (cpu_req && dbg_req) begin
      next_state = (burst_cnt == MAX_CNT) ? DBG_ACC : CPU_ACC;
    end else if (cpu_req) begin
      next_state = CPU_ACC;
    end else if (dbg_req) begin
      next_state = DBG_ACC;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// CPU/debug arbiter for the single-port data memory: ack one cycle after req, full throughput while held, stall until acked.
// Defining DMEM_ARB_STATS_EN adds saturating grant/conflict counters; arbitration is unchanged.
module dmem_arbiter
  import smachine_pkg::*;
#(
  parameter int ADDR_W    = SM_ADDR_W,
  parameter int DATA_W    = SM_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_grants,
  output logic [15:0]       stat_dbg_grants,
  output logic [15:0]       stat_conflicts
`endif
);
  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  dmem_arb_sel #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_sel (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .burst_cnt  (r_burst_cnt),
    .next_state (w_next)
  );

  // A slot whose owner dropped req is wasted: no ack and no write.
  always_comb begin
    cpu_ack        = (r_state == CPU_ACC) && cpu_req && !reset;
    dbg_ack        = (r_state == DBG_ACC) && dbg_req && !reset;
    mem_read_write = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (r_state)
      CPU_ACC: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (cpu_ack && cpu_we) mem_read_write = MEM_WRITE;
      end
      DBG_ACC: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        if (dbg_ack && dbg_we) mem_read_write = MEM_WRITE;
      end
      default: ;
    endcase
    cpu_rdata = cpu_ack ? mem_rdata : r_cpu_rdata;
    dbg_rdata = dbg_ack ? mem_rdata : r_dbg_rdata;
    cpu_stall = cpu_req && !cpu_ack && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (!dbg_req || w_next == DBG_ACC) begin
        r_burst_cnt <= '0;
      end else if (w_next == CPU_ACC && r_burst_cnt != MAX_CNT) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      if (cpu_ack) r_cpu_rdata <= mem_rdata;
      if (dbg_ack) r_dbg_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_cpu;
  logic [15:0] r_stat_dbg;
  logic [15:0] r_stat_conf;

  // Grants count performed accesses, so wasted slots are not included.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_cpu  <= '0;
      r_stat_dbg  <= '0;
      r_stat_conf <= '0;
    end else begin
      if (cpu_ack && r_stat_cpu != 16'hFFFF) r_stat_cpu <= r_stat_cpu + 16'd1;
      if (dbg_ack && r_stat_dbg != 16'hFFFF) r_stat_dbg <= r_stat_dbg + 16'd1;
      if (cpu_req && dbg_req && r_stat_conf != 16'hFFFF) r_stat_conf <= r_stat_conf + 16'd1;
    end
  end

  assign stat_cpu_grants = r_stat_cpu;
  assign stat_dbg_grants = r_stat_dbg;
  assign stat_conflicts  = r_stat_conf;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a combinational-read memory model.
// Latency checked: ack one cycle after req; full throughput while req is held.
// Backpressure checked: stall while unacked, burst-limited CPU priority; define DMEM_ARB_STATS_EN to cover the counters.
module tb_dmem_arbiter;
    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata, dbg_rdata;
    logic        mem_read_write;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_grants, stat_dbg_grants, stat_conflicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:255];
    logic        init_mem;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
        end else if (mem_read_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    dmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_ack        (dbg_ack),
        .dbg_rdata      (dbg_rdata),
        .mem_read_write (mem_read_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_grants(stat_cpu_grants),
        .stat_dbg_grants(stat_dbg_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    logic       exp_c, exp_d, exp_rw;
    logic [7:0] exp_addr;

    initial begin
        reset = 1'b1; init_mem = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;

        // Reset: a pending write request must stay silent
        next_cyc();
        cpu_req = 1'b1; cpu_we = 1'b1;
        #2;
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_rw", mem_read_write, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
        chk("rst_dbg_rdata", dbg_rdata, 16'h0000);
        next_cyc();
        reset = 1'b0; init_mem = 1'b0;

        // Test 1: CPU write BEEF to 0x10, then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        #2;
        chk("t1_idle_ack", cpu_ack, 1'b0);
        chk("t1_idle_stall", cpu_stall, 1'b1);
        chk("t1_idle_rw", mem_read_write, 1'b0);
        chk("t1_idle_addr", mem_addr, 8'h00);
        next_cyc();
        #2;
        chk("t1_wr_ack", cpu_ack, 1'b1);
        chk("t1_wr_stall", cpu_stall, 1'b0);
        chk("t1_wr_rw", mem_read_write, 1'b1);
        chk("t1_wr_addr", mem_addr, 8'h10);
        chk("t1_wr_wdata", mem_wdata, 16'hBEEF);
        next_cyc();
        cpu_we = 1'b0;
        #2;
        chk("t1_rd_ack", cpu_ack, 1'b1);
        chk("t1_rd_rw", mem_read_write, 1'b0);
        chk("t1_rd_rdata", cpu_rdata, 16'hBEEF);
        next_cyc();
        cpu_req = 1'b0; cpu_addr = 8'h55;
        #2;
        chk("t1_drop_ack", cpu_ack, 1'b0);
        chk("t1_hold_rdata", cpu_rdata, 16'hBEEF);
        next_cyc();
        #2;
        chk("t1_idle2_addr", mem_addr, 8'h00);
        chk("t1_idle2_stall", cpu_stall, 1'b0);

        // Test 3: debug-only reads of 0x00..0x03
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h00;
        #2;
        chk("t3_idle_ack", dbg_ack, 1'b0);
        for (int k = 0; k < 4; k++) begin
            next_cyc();
            dbg_addr = 8'(k);
            #2;
            chk("t3_dbg_ack", dbg_ack, 1'b1);
            chk("t3_dbg_rdata", dbg_rdata, 16'hA000 | 16'(k));
            chk("t3_cpu_ack", cpu_ack, 1'b0);
            chk("t3_cpu_rdata", cpu_rdata, 16'hBEEF);
        end
        next_cyc();
        dbg_req = 1'b0;
        #2;
        chk("t3_drop_ack", dbg_ack, 1'b0);
        chk("t3_hold_rdata", dbg_rdata, 16'hA003);

        // Test 5: CPU abandons its slot while debug is waiting
        next_cyc();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'hDEAD;
        next_cyc();
        cpu_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h40;
        #2;
        chk("t5_cpu_ack", cpu_ack, 1'b0);
        chk("t5_rw", mem_read_write, 1'b0);
        chk("t5_dbg_ack_early", dbg_ack, 1'b0);
        next_cyc();
        #2;
        chk("t5_dbg_ack", dbg_ack, 1'b1);
        chk("t5_dbg_rdata", dbg_rdata, 16'hA040);
        next_cyc();
        dbg_req = 1'b0;
        next_cyc();

        // Test 4: reset lands on the CPU_ACC cycle of a write to 0x20
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'h5555;
        #2;
        chk("t4_idle_ack", cpu_ack, 1'b0);
        next_cyc();
        reset = 1'b1;
        #2;
        chk("t4_rst_rw", mem_read_write, 1'b0);
        chk("t4_rst_ack", cpu_ack, 1'b0);
        chk("t4_rst_stall", cpu_stall, 1'b0);
        next_cyc();
        reset = 1'b0; cpu_we = 1'b0;
        #2;
        chk("t4_post_ack", cpu_ack, 1'b0);
        chk("t4_post_addr", mem_addr, 8'h00);
        chk("t4_post_cpu_rdata", cpu_rdata, 16'h0000);
        chk("t4_post_dbg_rdata", dbg_rdata, 16'h0000);
        next_cyc();
        #2;
        chk("t4_rd_ack", cpu_ack, 1'b1);
        chk("t4_rd_old", cpu_rdata, 16'hA020);
        next_cyc();
        cpu_req = 1'b0; reset = 1'b1;

        // Test 2/6: both ports write continuously; CPU gets 4 then debug gets 1
        next_cyc();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 16'h1111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h31; dbg_wdata = 16'h2222;
`ifdef DMEM_ARB_STATS_EN
        #2;
        chk("t6_rst_cpu_grants", stat_cpu_grants, 16'd0);
        chk("t6_rst_conflicts", stat_conflicts, 16'd0);
        #1;
`endif
        for (int c = 0; c < 10; c++) begin
            exp_c    = (c != 0) && (c != 5);
            exp_d    = (c == 5);
            exp_rw   = (c != 0);
            exp_addr = (c == 0) ? 8'h00 : ((c == 5) ? 8'h31 : 8'h30);
            #2;
            chk("t2_cpu_ack", cpu_ack, exp_c);
            chk("t2_dbg_ack", dbg_ack, exp_d);
            chk("t2_rw", mem_read_write, exp_rw);
            chk("t2_addr", mem_addr, exp_addr);
            next_cyc();
        end
        cpu_req = 1'b0;
        #2;
        chk("t2_tail_dbg_ack", dbg_ack, 1'b1);
        chk("t2_tail_cpu_ack", cpu_ack, 1'b0);
        chk("t2_tail_addr", mem_addr, 8'h31);
        next_cyc();
        dbg_req = 1'b0;
        #2;
        chk("t2_end_dbg_ack", dbg_ack, 1'b0);
        chk("t2_end_rw", mem_read_write, 1'b0);
`ifdef DMEM_ARB_STATS_EN
        chk("t6_cpu_grants", stat_cpu_grants, 16'd8);
        chk("t6_dbg_grants", stat_dbg_grants, 16'd2);
        chk("t6_conflicts", stat_conflicts, 16'd10);
`endif
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
